// File: rtl/emb_forward_unit_if.sv
// Interface for the embedding fetch unit. It bundles the start/data handshake,
// the result bus and the external RAM read port.
interface emb_forward_unit_if #(
  parameter int N          = 10,
  parameter int CHAR_LEN   = 8,
  parameter int EMB_DIM    = 24,
  parameter int N_LEN_W    = 16,
  parameter int DATA_N     = 8,
  parameter int ADDR_WIDTH = 10
) ();
  logic                            run;
  logic [N*CHAR_LEN-1:0]           d;
  logic                            valid;
  logic [N*EMB_DIM*N_LEN_W-1:0]    q;
  logic [ADDR_WIDTH-1:0]           addr;
  logic [DATA_N*N_LEN_W-1:0]       rdata;

  // The producer side also hosts the RAM, so it drives rdata.
  modport master (output run, d, rdata, input valid, q, addr);
  modport slave  (input run, d, rdata, output valid, q, addr);
endinterface

// File: rtl/emb_forward_unit.sv
// Embedding lookup: for each of N characters, read EMB_DIM/DATA_N lines from a
// synchronous-read RAM and assemble them into one wide output vector q.
module emb_forward_unit #(
  parameter int N          = 10,
  parameter int CHAR_LEN   = 8,
  parameter int CHAR_NUM   = 200,
  parameter int EMB_DIM    = 24,
  parameter int N_LEN_W    = 16,
  parameter int DATA_N     = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  emb_forward_unit_if.slave bus
);
  localparam int L      = EMB_DIM / DATA_N;
  localparam int R      = N * L;
  localparam int CNT_W  = $clog2(R + 1);
  localparam int CH_W   = $clog2(N + 1);
  localparam int LN_W   = $clog2(L + 1);
  localparam int LINE_W = DATA_N * N_LEN_W;
  localparam int Q_W    = N * EMB_DIM * N_LEN_W;

  if ((EMB_DIM % DATA_N) != 0 || CHAR_NUM * L > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("emb_forward_unit: EMB_DIM/DATA_N/ADDR_WIDTH inconsistent with CHAR_NUM");
  end

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // reads issued so far in this pass
  logic [CH_W-1:0]    ch_q, ch_d;       // character being addressed
  logic [LN_W-1:0]    ln_q, ln_d;       // line within that character
  logic               valid_q, valid_d;
  logic [Q_W-1:0]     q_q, q_d;
  logic [CHAR_LEN-1:0]   cur_char;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_W-1:0]   cap_idx;
  logic               capture;

  always_comb begin
    cur_char = bus.d[int'(ch_q) * CHAR_LEN +: CHAR_LEN];
    rd_addr  = '0;
    if (state_q == READ)
      rd_addr = ADDR_WIDTH'(cur_char) * ADDR_WIDTH'(L) + ADDR_WIDTH'(ln_q);
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    ln_d    = ln_q;
    valid_d = 1'b0;
    q_d     = q_q;
    // rdata always belongs to the read issued one cycle earlier, i.e. cnt_q-1.
    capture = (state_q == READ && cnt_q != '0) || state_q == WAIT;
    cap_idx = cnt_q - CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.run) begin
          state_d = READ;
          cnt_d   = '0;
          ch_d    = '0;
          ln_d    = '0;
        end
      end
      READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ln_q == LN_W'(L - 1)) begin
          ln_d = '0;
          ch_d = ch_q + CH_W'(1);
        end else begin
          ln_d = ln_q + LN_W'(1);
        end
        if (cnt_q == CNT_W'(R - 1)) state_d = WAIT;
      end
      WAIT: begin
        state_d = DONE;
        valid_d = 1'b1;
      end
      DONE: valid_d = 1'b1;
      default: state_d = IDLE;
    endcase

    if (!bus.run) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else if (capture) begin
      q_d[int'(cap_idx) * LINE_W +: LINE_W] = bus.rdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; q is a plain register (not RAM), so it can and must
  // be cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      ln_q    <= '0;
      valid_q <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      ln_q    <= ln_d;
      valid_q <= valid_d;
      q_q     <= q_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.q     = q_q;
  assign bus.addr  = rd_addr;
endmodule

// File: tb/tb_emb_forward_unit.sv
// Directed bench for emb_forward_unit with a synchronous RAM model whose line m
// holds words m*8+w.
module tb_emb_forward_unit;
  localparam int N = 10, CHAR_LEN = 8, CHAR_NUM = 200, EMB_DIM = 24;
  localparam int N_LEN_W = 16, DATA_N = 8, ADDR_WIDTH = 10;
  localparam int L = EMB_DIM / DATA_N;
  localparam int R = N * L;
  localparam int Q_W = N * EMB_DIM * N_LEN_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  emb_forward_unit_if #(.N(N), .CHAR_LEN(CHAR_LEN), .EMB_DIM(EMB_DIM), .N_LEN_W(N_LEN_W),
                        .DATA_N(DATA_N), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  emb_forward_unit #(.N(N), .CHAR_LEN(CHAR_LEN), .CHAR_NUM(CHAR_NUM), .EMB_DIM(EMB_DIM),
                     .N_LEN_W(N_LEN_W), .DATA_N(DATA_N), .ADDR_WIDTH(ADDR_WIDTH))
    dut (.clk(clk), .rst(rst), .bus(bus));

  // Synchronous-read RAM: rdata reflects the address sampled at the last edge.
  always @(posedge clk)
    for (int w = 0; w < DATA_N; w++)
      bus.rdata[w*N_LEN_W +: N_LEN_W] <= 16'(int'(bus.addr) * DATA_N + w);

  int tests = 0;
  int fails = 0;
  logic [7:0]     dv [N];
  logic [Q_W-1:0] gold;
  logic [Q_W-1:0] zero_q = '0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [Q_W-1:0] exp);
    int k;
    k = 0;
    for (int i = 0; i < N*EMB_DIM; i++)
      if (bus.q[i*N_LEN_W +: N_LEN_W] !== exp[i*N_LEN_W +: N_LEN_W]) begin
        k = i;
        break;
      end
    tests++;
    assert (bus.q === exp) else begin
      fails++;
      $error("FAIL %s: q word %0d observed %0h expected %0h", tag, k,
             bus.q[k*N_LEN_W +: N_LEN_W], exp[k*N_LEN_W +: N_LEN_W]);
    end
  endtask

  // Pack dv onto d and build the expected q from the RAM contents.
  task automatic load_d();
    int line;
    for (int i = 0; i < N; i++) begin
      bus.d[i*CHAR_LEN +: CHAR_LEN] = dv[i];
      for (int e = 0; e < EMB_DIM; e++) begin
        line = int'(dv[i]) * L + e / DATA_N;
        gold[(i*EMB_DIM + e)*N_LEN_W +: N_LEN_W] = 16'(line * DATA_N + e % DATA_N);
      end
    end
  endtask

  // Full pass from IDLE: checks address order, valid timing and final q.
  task automatic run_pass(input string tag, input bit q_stable);
    int addr_err, early, q_moved, exp_addr;
    addr_err = 0; early = 0; q_moved = 0;
    bus.run = 1'b1;
    for (int k = 1; k <= R + 2; k++) begin
      tick();
      if (k <= R) begin
        exp_addr = int'(dv[(k-1) / L]) * L + (k-1) % L;
        if (bus.addr !== ADDR_WIDTH'(exp_addr)) addr_err++;
      end
      if (k < R + 2 && bus.valid !== 1'b0) early++;
      if (q_stable && bus.q !== gold) q_moved++;
    end
    check({tag, "_addr_seq_errors"}, addr_err, 0);
    check({tag, "_valid_early"}, early, 0);
    if (q_stable) check({tag, "_q_stable"}, q_moved, 0);
    check({tag, "_valid_at_R+2"}, {31'b0, bus.valid}, 1);
    check({tag, "_addr_done"}, {22'b0, bus.addr}, 0);
    check_q({tag, "_q"}, gold);
  endtask

  initial begin
    bus.run = 1'b0;
    bus.d   = '0;
    rst     = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("reset_valid", {31'b0, bus.valid}, 0);
    check("reset_addr", {22'b0, bus.addr}, 0);
    check_q("reset_q", zero_q);

    // Identity characters: q word k equals k.
    for (int i = 0; i < N; i++) dv[i] = 8'(i);
    load_d();
    for (int k = 0; k < N*EMB_DIM; k++)
      if (gold[k*N_LEN_W +: N_LEN_W] !== 16'(k)) $fatal(1, "FAIL golden_setup word %0d", k);
    run_pass("ident", 1'b0);

    // run held in DONE: valid stays, no reads.
    for (int k = 0; k < 5; k++) begin
      tick();
      check("done_hold_valid", {31'b0, bus.valid}, 1);
      check("done_hold_addr", {22'b0, bus.addr}, 0);
    end

    // One-cycle run drop then restart.
    bus.run = 1'b0;
    tick();
    check("drop_valid", {31'b0, bus.valid}, 0);
    check("drop_addr", {22'b0, bus.addr}, 0);
    check_q("drop_q_kept", gold);
    run_pass("restart", 1'b1);

    // Last vocabulary row everywhere: addresses 597..599 repeating.
    bus.run = 1'b0;
    tick();
    for (int i = 0; i < N; i++) dv[i] = 8'd199;
    load_d();
    run_pass("last_row", 1'b0);

    // Abort mid-read with run low, then a random pass.
    bus.run = 1'b0;
    tick();
    bus.run = 1'b1;
    repeat (5) tick();
    bus.run = 1'b0;
    tick();
    check("abort_valid", {31'b0, bus.valid}, 0);
    check("abort_addr", {22'b0, bus.addr}, 0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < N; i++) dv[i] = 8'($urandom_range(0, CHAR_NUM - 1));
      load_d();
      run_pass($sformatf("rand%0d", p), 1'b0);
      bus.run = 1'b0;
      tick();
    end

    // Asynchronous reset just after edge 10 of a pass.
    for (int i = 0; i < N; i++) dv[i] = 8'($urandom_range(0, CHAR_NUM - 1));
    load_d();
    bus.run = 1'b1;
    repeat (9) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'b0, bus.valid}, 0);
    check("rst_mid_addr", {22'b0, bus.addr}, 0);
    check_q("rst_mid_q", zero_q);
    @(negedge clk);
    bus.run = 1'b0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_idle_valid", {31'b0, bus.valid}, 0);
    check("post_rst_idle_addr", {22'b0, bus.addr}, 0);
    run_pass("post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/emb_forward_unit.md
EMB_FORWARD_UNIT -- requirements
Module: emb_forward_unit

Interface
REQ-001 Parameter N, default 10: characters per input sequence.
REQ-002 Parameter CHAR_LEN, default 8: bit width of one character index.
REQ-003 Parameter CHAR_NUM, default 200: vocabulary size, i.e. number of embedding rows.
REQ-004 Parameter EMB_DIM, default 24: embedding words per character; SHALL be a multiple of DATA_N.
REQ-005 Parameter N_LEN_W, default 16: bit width of one fixed-point word.
REQ-006 Parameter DATA_N, default 8: words per external RAM line.
REQ-007 Parameter ADDR_WIDTH, default 10: RAM address width; SHALL hold CHAR_NUM*EMB_DIM/DATA_N lines.
REQ-008 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-009 Port rst, input, 1: reset, asynchronous and active-high.
REQ-010 Port run, input, 1: level-sensitive start/enable.
REQ-011 Port d, input, N*CHAR_LEN: character i occupies bits [i*CHAR_LEN +: CHAR_LEN].
REQ-012 Port valid, output, 1: result ready.
REQ-013 Port q, output, N*EMB_DIM*N_LEN_W: embedding output; word k occupies bits [k*N_LEN_W +: N_LEN_W], with k = i*EMB_DIM + e.
REQ-014 Port addr, output, ADDR_WIDTH: external RAM read address.
REQ-015 Port rdata, input, DATA_N*N_LEN_W: external RAM line; word w occupies bits [w*N_LEN_W +: N_LEN_W].

Function
REQ-016 External RAM SHALL be treated as synchronous read: rdata reflects the addr sampled at the previous rising edge.
REQ-017 Line index within a character SHALL be j = 0..EMB_DIM/DATA_N-1 (L = EMB_DIM/DATA_N lines per character).
REQ-018 The address for character i, line j SHALL be d[i]*L + j, computed at ADDR_WIDTH bits.
REQ-019 Total reads per run SHALL be R = N*L (30 at defaults), issued one per cycle, i-major then j.
REQ-020 Data returned for (i,j) SHALL be written to q words i*EMB_DIM + j*DATA_N + w, w = 0..DATA_N-1, with rdata word w mapped to q word offset w.
REQ-021 The FSM SHALL have states IDLE, READ, WAIT and DONE.
REQ-022 IDLE -> READ when run = 1; the read counter is cleared.
REQ-023 READ SHALL issue reads 0..R-1, capturing each rdata one cycle after its address; after the last address it SHALL go to WAIT.
REQ-024 WAIT SHALL capture the final line, then go to DONE.
REQ-025 In DONE, valid = 1 and q SHALL hold all R lines.
REQ-026 valid SHALL be registered and SHALL rise exactly R+2 rising edges after the first edge that samples run = 1 in IDLE.
REQ-027 run = 0 in any state SHALL return the FSM to IDLE and clear valid on the next edge; q SHALL keep its last contents.
REQ-028 run held high in DONE SHALL keep valid = 1 with no new reads.
REQ-029 run falling then rising SHALL start a full new pass; valid stays 0 until that pass completes.
REQ-030 d SHALL be held stable by the producer while run = 1; the unit does not latch d.
REQ-031 In IDLE and DONE, addr SHALL be 0.

Reset
REQ-032 While rst = 1, regardless of clk: state = IDLE, counters = 0, valid = 0, q = 0, addr = 0.
REQ-033 Reset asserted mid-pass SHALL abort the pass; after release the unit SHALL wait in IDLE for run.

Verification
REQ-034 After reset with run = 0 for 4 cycles -> valid = 0, q = 0, addr = 0.
REQ-035 RAM line m preloaded with words (m*8+w); d = {0,1,...,9}; run = 1 -> valid at edge 32; q word i*24+e equals i*24+e.
REQ-036 d with all characters = 199 (last row) -> addresses 597, 598, 599 repeat ten times; every q block equals RAM lines 597-599.
REQ-037 After valid, drop run for 1 cycle, then raise it again -> valid = 0 at the next edge; valid returns after 32 edges; q is unchanged in between.
REQ-038 Assert rst at edge 10 of a pass -> valid = 0 and q = 0 immediately; a new run then completes normally.
REQ-039 Throughout, compare q against a golden embedding table for a random d (indices < CHAR_NUM) -> exact match once valid = 1.
